// File: rtl/fetch_stage.sv
// Purpose: MIPS fetch stage (PC, imem address) and IF/ID pipeline register; optional perf counters via FETCH_PERF_CNT_EN.
// Latency: 1 cycle from PC to IF/ID; taken branch or jump costs one bubble in IF/ID.
// Backpressure: stall holds PC and IF/ID; a taken branch overrides stall, a jump waits for stall to drop.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [5:0]  opcode,
  output logic        flush_ex,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
);

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_branch_pc;
  logic [31:0] w_jump_pc;
  logic        w_jump_take;
  logic        w_unused_bits;

  // Branch targets are word-aligned by dropping the low address bits.
  assign w_unused_bits = &{1'b0, branch_target[1:0]};

  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_branch_pc = {branch_target[31:2], 2'b00};
  assign w_jump_pc   = {r_pc_plus4[31:28], r_instr[25:0], 2'b00};
  // A jump only counts for a real instruction in ID and only when ID can move on.
  assign w_jump_take = jump & r_valid & ~stall;

  assign imem_addr      = r_pc;
  assign if_id_instr    = r_instr;
  assign if_id_pc_plus4 = r_pc_plus4;
  assign if_id_valid    = r_valid;
  assign opcode         = r_instr[31:26];
  assign flush_ex       = branch_taken;

  // PC and IF/ID update: reset, branch, jump, stall, sequential fetch in priority order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_instr    <= 32'h0;
      r_pc_plus4 <= 32'h0;
      r_valid    <= 1'b0;
    end else if (branch_taken) begin
      r_pc       <= w_branch_pc;
      r_instr    <= 32'h0;
      r_pc_plus4 <= 32'h0;
      r_valid    <= 1'b0;
    end else if (w_jump_take) begin
      r_pc       <= w_jump_pc;
      r_instr    <= 32'h0;
      r_pc_plus4 <= 32'h0;
      r_valid    <= 1'b0;
    end else if (!stall) begin
      r_pc       <= w_pc_plus4;
      r_instr    <= imem_rdata;
      r_pc_plus4 <= w_pc_plus4;
      r_valid    <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_bubbles;

  // Count redirect bubbles and real fetches; stalled cycles leave both untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_fetched <= 32'h0;
      r_perf_bubbles <= 32'h0;
    end else if (branch_taken || w_jump_take) begin
      r_perf_bubbles <= r_perf_bubbles + 32'd1;
    end else if (!stall) begin
      r_perf_fetched <= r_perf_fetched + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_bubbles = r_perf_bubbles;
`else
  assign perf_fetched = 32'h0;
  assign perf_bubbles = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose: randomized and directed check of fetch_stage against a behavioural model.
// Latency: model state advances on each rising edge; outputs compared on the falling edge.
// Backpressure: stall, branch and jump are driven randomly and in directed corner cases.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic [5:0]  opcode;
  logic        flush_ex;
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // Behavioural state: architectural PC, contents of IF/ID, event counts.
  logic [31:0] m_pc, m_instr, m_pc4;
  bit          m_valid;
  int unsigned m_fetched, m_bubbles;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .jump(jump),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid), .opcode(opcode), .flush_ex(flush_ex),
    .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
  );

  // Instruction memory: word i holds i+1, except one planted J instruction.
  function automatic logic [31:0] imem_f(input logic [31:0] a);
    if (a == 32'h1000_0004) return 32'h0800_0010;
    return (a >> 2) + 32'd1;
  endfunction

  assign imem_rdata = imem_f(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_fetched();
`ifdef FETCH_PERF_CNT_EN
    return m_fetched;
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [31:0] exp_bubbles();
`ifdef FETCH_PERF_CNT_EN
    return m_bubbles;
`else
    return 32'h0;
`endif
  endfunction

  // Apply the fetch rules to the model for one rising edge.
  task automatic model_edge();
    if (reset) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 0;
      m_fetched = 0; m_bubbles = 0;
    end else if (branch_taken) begin
      m_pc = branch_target & ~32'h3;
      m_instr = 32'h0; m_valid = 0; m_bubbles++;
    end else if (jump && m_valid && !stall) begin
      m_pc = (m_pc4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
      m_instr = 32'h0; m_valid = 0; m_bubbles++;
    end else if (!stall) begin
      m_instr = imem_f(m_pc);
      m_pc = m_pc + 32'd4;
      m_pc4 = m_pc;
      m_valid = 1; m_fetched++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic drive(input bit r, input bit bt, input logic [31:0] tgt, input bit st, input bit j);
    reset = r; branch_taken = bt; branch_target = tgt; stall = st; jump = j;
  endtask

  // Single compare process against the model on every falling edge.
  always @(negedge clk) begin
    if (started) begin
      chk("pc", imem_addr, m_pc);
      chk("valid", {31'b0, if_id_valid}, {31'b0, m_valid});
      chk("instr", if_id_instr, m_instr);
      chk("opcode", {26'b0, opcode}, {26'b0, m_instr[31:26]});
      if (m_valid) chk("pc_plus4", if_id_pc_plus4, m_pc4);
      chk("flush_ex", {31'b0, flush_ex}, {31'b0, branch_taken});
      chk("perf_fetched", perf_fetched, exp_fetched());
      chk("perf_bubbles", perf_bubbles, exp_bubbles());
    end
  end

  initial begin
    drive(1, 0, 32'h0, 0, 0);
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_fetched = 0; m_bubbles = 0;
    tick(); tick();
    started = 1'b1;
    chk("lit_reset_pc", imem_addr, 32'h0);
    chk("lit_reset_valid", {31'b0, if_id_valid}, 32'h0);

    // Free run: addresses 0,4,8 with instructions 1,2 one cycle behind.
    drive(0, 0, 32'h0, 0, 0);
    tick();
    chk("lit_run_pc4", imem_addr, 32'h4);
    chk("lit_run_instr1", if_id_instr, 32'h1);
    tick();
    chk("lit_run_pc8", imem_addr, 32'h8);
    chk("lit_run_instr2", if_id_instr, 32'h2);

    // Three stall cycles at pc=8, then resume with word 3.
    drive(0, 0, 32'h0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lit_stall_pc", imem_addr, 32'h8);
      chk("lit_stall_instr", if_id_instr, 32'h2);
    end
    drive(0, 0, 32'h0, 0, 0);
    tick();
    chk("lit_resume_pc", imem_addr, 32'hC);
    chk("lit_resume_instr", if_id_instr, 32'h3);

    // Branch together with stall: redirect wins.
    drive(0, 1, 32'h40, 1, 0);
    #1 chk("lit_flush", {31'b0, flush_ex}, 32'h1);
    tick();
    chk("lit_br_pc", imem_addr, 32'h40);
    chk("lit_br_valid", {31'b0, if_id_valid}, 32'h0);
    chk("lit_br_opcode", {26'b0, opcode}, 32'h0);
    drive(0, 0, 32'h0, 0, 0);
    tick();
    chk("lit_br_target_instr", if_id_instr, 32'h11);

    // Reach the planted J instruction and take the jump.
    drive(0, 1, 32'h1000_0004, 0, 0);
    tick();
    drive(0, 0, 32'h0, 0, 0);
    tick();
    chk("lit_j_instr", if_id_instr, 32'h0800_0010);
    chk("lit_j_pc4", if_id_pc_plus4, 32'h1000_0008);
    drive(0, 0, 32'h0, 0, 1);
    tick();
    chk("lit_j_pc", imem_addr, 32'h1000_0040);
    chk("lit_j_bubble", {31'b0, if_id_valid}, 32'h0);
    drive(0, 0, 32'h0, 0, 0);
    tick();
    chk("lit_j_target_instr", if_id_instr, 32'h0400_0011);

    // Branch and jump in the same cycle: branch wins.
    drive(0, 1, 32'h80, 0, 1);
    tick();
    chk("lit_bj_pc", imem_addr, 32'h80);
    drive(0, 0, 32'h0, 0, 0);
    tick();

    // Wrap at the top of the address space; low target bits are dropped.
    drive(0, 1, 32'hFFFF_FFFE, 0, 0);
    tick();
    chk("lit_wrap_pc", imem_addr, 32'hFFFF_FFFC);
    drive(0, 0, 32'h0, 0, 0);
    tick();
    chk("lit_wrap_pc0", imem_addr, 32'h0);
    chk("lit_wrap_instr", if_id_instr, 32'h4000_0000);
    chk("lit_wrap_pc4", if_id_pc_plus4, 32'h0);

    // Counter scenario: 10 fetches, 1 branch, 1 jump, 2 stalls after reset.
    drive(1, 0, 32'h0, 0, 0);
    tick();
    drive(0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 8; i++) tick();
    drive(0, 0, 32'h0, 1, 0);
    tick(); tick();
    drive(0, 1, 32'h100, 0, 0);
    tick();
    drive(0, 0, 32'h0, 0, 0);
    tick();
    drive(0, 0, 32'h0, 0, 1);
    tick();
    drive(0, 0, 32'h0, 0, 0);
    tick();
`ifdef FETCH_PERF_CNT_EN
    chk("lit_perf_fetched", perf_fetched, 32'd10);
    chk("lit_perf_bubbles", perf_bubbles, 32'd2);
`else
    chk("lit_perf_fetched", perf_fetched, 32'd0);
    chk("lit_perf_bubbles", perf_bubbles, 32'd0);
`endif

    // Random traffic, including reset mid-stall or mid-redirect.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3) : $urandom;
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0, tgt,
            $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
      tick();
    end

    drive(0, 0, 32'h0, 0, 0);
    tick();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
